conv_tap_sched: RTL and testbench
=================================

# conv_tap_sched

Sequencing controller for the conv layer's shared three-tap multiplier (`mult_mux`). It accepts kernel-window rows of three activation/weight pairs over a valid/ready handshake and registers them onto the multiplier operand ports. It steps the multiplier select through taps 1..3, accumulates the one-cycle-late products over ROWS rows, and presents the window sum downstream over a second valid/ready handshake. It sits between the window/line-buffer front end and the conv output stage.

## Interface
- ROWS, 3: rows per kernel window (≥1); one window = 3·ROWS products
- DW, 8: product and operand width
- AW, 12: accumulator / output sum width (AW ≥ DW)
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- row_valid  in  1  row_a/row_k hold a valid row
- row_ready  out  1  controller can accept a row this cycle
- row_a  in  3·DW  activations, tap0 in [DW-1:0], tap2 in MSBs
- row_k  in  3·DW  weights, same packing
- mm_sel  out  2  multiplier select: 00 idle, 01/10/11 = tap0/1/2
- mm_a  out  3·DW  registered activations to multiplier a0..a2
- mm_k  out  3·DW  registered weights to multiplier k0..k2
- mm_product  in  DW  multiplier result, valid one cycle after its mm_sel
- out_valid  out  1  out_sum holds a finished window
- out_ready  in  1  downstream accepts
- out_sum  out  AW  window sum, unsigned
- out_ovf  out  1  sticky: accumulator exceeded 2^AW−1 during this window

## Operation
- States: IDLE, MUL, WAIT_ROW, DRAIN, DONE; 2-bit tap counter; row counter of width clog2(ROWS)+1.
- IDLE: row_ready=1, mm_sel=00. On row_valid: latch row_a/row_k into mm_a/mm_k, clear acc, ovf, and row counter → MUL with tap=0.
- MUL: mm_sel = tap+1; tap increments each cycle. After tap 2: if this is the last row → DRAIN, else → WAIT_ROW.
- WAIT_ROW: row_ready=1, mm_sel=00. On row_valid: latch the new row, increment the row counter → MUL with tap=0. Otherwise hold.
- DRAIN: mm_sel=00, absorbs the last product → DONE.
- DONE: out_valid=1; out_sum/out_ovf stable. On out_ready → IDLE. row_ready=0 in DONE, including the handshake cycle.
- Accumulate: a product-pending flag is registered from (state==MUL). When the flag is set, acc ← acc + zero-extend(mm_product) in any state. No other cycle adds.
- Overflow: an AW+1-bit sum with carry out sets out_ovf, which stays set until the next window starts.
- mm_a/mm_k change only on a row accept; they are stable through every MUL cycle.
- row_a/row_k are ignored when row_ready=0.

## Timing
- Reset values (rst_n low at an edge): state IDLE, mm_sel=00, mm_a=mm_k=0, out_sum=0, out_valid=0, out_ovf=0, row_ready=0 during the reset cycle and 1 in the first cycle after, pending flag=0.
- Row accepted at edge c0: mm_sel=01/10/11 in cycles c1/c2/c3; products land in acc at c2/c3/c4.
- With back-to-back rows and ROWS=3: row0 at c0, row1 at c4, row2 at c8, DRAIN at c12, out_valid from c13. In general out_valid appears 4·ROWS+1 cycles after the first accept.
- WAIT_ROW stalls of n cycles add n cycles to latency; no product is lost because the pending flag covers the first WAIT_ROW cycle.
- Reset mid-window: the window is discarded; no out_valid, accumulator zeroed.
- Minimum window-to-window spacing: out handshake at cycle d, IDLE at d+1, next row accepted at d+1 at the earliest.

## Configuration
- CONV_TAP_SAT_EN defined: on overflow, acc saturates to 2^AW−1 and stays there for the rest of the window; out_ovf=1.
- CONV_TAP_SAT_EN undefined: acc wraps modulo 2^AW; out_ovf is still set, sticky.

## Test plan
Bench stub for the multiplier: registered product = (a_sel·k_sel) mod 2^DW one cycle after mm_sel; product holds when mm_sel=00.
- Back-to-back rows, ROWS=3, each row a=(1,2,3), k=(4,5,6): mm_sel sequence 01,10,11 per row; out_valid at c13 with out_sum=96, out_ovf=0.
- Row gaps: row_valid low 3 cycles in each WAIT_ROW: mm_sel=00 during gaps; acc unchanged; out_sum=96 at c19.
- Overflow, AW=8, all products 200 (a=20, k=10): with CONV_TAP_SAT_EN, out_sum=255 and out_ovf=1; without it, out_sum=1800 mod 256=8 and out_ovf=1.
- Backpressure: out_ready low 5 cycles in DONE: out_valid, out_sum and out_ovf stable; row_ready=0; after the handshake, row_ready=1 the next cycle.
- Reset mid-window: rst_n low at c6 for one cycle: all outputs at reset values; a new window afterwards sums from 0 (96 for the first stimulus).
- ROWS=1 with a=(255,1,0), k=(1,1,0): out_sum=256 at c5 when AW=12.

Source files
------------

// File: rtl/conv_tap_sched_if.sv
// conv_tap_sched_if: bundles the row handshake, the multiplier operand/select
// bus and the window-sum handshake of the conv tap scheduler.
//   master : the scheduler (drives mm_*, row_ready and the out_* result)
//   slave  : the surrounding environment (line buffer, mult_mux, output stage)
interface conv_tap_sched_if #(
  parameter int DW = 8,
  parameter int AW = 12
);
  // Row input handshake from the window / line-buffer front end
  logic              row_valid;
  logic              row_ready;
  logic [3*DW-1:0]   row_a;
  logic [3*DW-1:0]   row_k;

  // Shared three-tap multiplier operands, select and returned product
  logic [1:0]        mm_sel;
  logic [3*DW-1:0]   mm_a;
  logic [3*DW-1:0]   mm_k;
  logic [DW-1:0]     mm_product;

  // Window-sum handshake towards the conv output stage
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_sum;
  logic              out_ovf;

  modport master (
    input  row_valid, row_a, row_k, mm_product, out_ready,
    output row_ready, mm_sel, mm_a, mm_k, out_valid, out_sum, out_ovf
  );

  modport slave (
    output row_valid, row_a, row_k, mm_product, out_ready,
    input  row_ready, mm_sel, mm_a, mm_k, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/conv_tap_sched.sv
// conv_tap_sched: sequencing controller for the conv layer's shared three-tap
// multiplier. Accepts kernel-window rows, registers them onto the multiplier
// operand ports, steps the select through taps 0..2, accumulates the
// one-cycle-late products over ROWS rows and hands the window sum downstream.
//
// Optional feature macro: CONV_TAP_SAT_EN
//   defined   -> accumulator saturates at 2^AW-1 once it overflows and stays
//                there for the rest of the window
//   undefined -> accumulator wraps modulo 2^AW
//   out_ovf is a sticky per-window overflow flag in both builds.
//
// All outputs come straight from registers; next-state decisions are made
// one cycle ahead so that row_ready/mm_sel/out_valid line up with the state.
module conv_tap_sched #(
  parameter int ROWS = 3,
  parameter int DW   = 8,
  parameter int AW   = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_tap_sched_if.master   bus
);

  localparam int RCW = $clog2(ROWS) + 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL      = 3'd1,
    WAIT_ROW = 3'd2,
    DRAIN    = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Sequencer state
  state_t            state_r;
  state_t            state_nxt_s;
  logic [1:0]        tap_r;
  logic [1:0]        tap_nxt_s;
  logic [RCW-1:0]    row_cnt_r;
  logic [RCW-1:0]    row_cnt_nxt_s;

  // Control strobes from the next-state logic
  logic              accept_s;
  logic              load_s;
  logic              clr_s;
  logic              last_row_s;

  // Product-pending flag: the multiplier result for last cycle's select
  logic              pend_r;

  // Accumulator and sticky overflow
  logic [AW-1:0]     acc_r;
  logic [AW-1:0]     acc_nxt_s;
  logic              ovf_r;
  logic              ovf_nxt_s;
  logic [AW:0]       sum_s;

  // Registered outputs
  logic [3*DW-1:0]   mm_a_r;
  logic [3*DW-1:0]   mm_k_r;
  logic [1:0]        mm_sel_r;
  logic              row_ready_r;
  logic              out_valid_r;

  // row_ready_r is only ever set for IDLE / WAIT_ROW, so it gates the accept
  assign accept_s   = row_ready_r & bus.row_valid;
  assign last_row_s = (row_cnt_r == RCW'(ROWS - 1));

  // Next-state, tap/row counters and row-load strobes
  always_comb begin
    state_nxt_s   = state_r;
    tap_nxt_s     = tap_r;
    row_cnt_nxt_s = row_cnt_r;
    load_s        = 1'b0;
    clr_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          load_s        = 1'b1;
          clr_s         = 1'b1;
          row_cnt_nxt_s = '0;
          tap_nxt_s     = 2'd0;
          state_nxt_s   = MUL;
        end else begin
          state_nxt_s   = IDLE;
        end
      end
      MUL: begin
        if (tap_r == 2'd2) begin
          tap_nxt_s   = 2'd0;
          state_nxt_s = last_row_s ? DRAIN : WAIT_ROW;
        end else begin
          tap_nxt_s   = tap_r + 2'd1;
          state_nxt_s = MUL;
        end
      end
      WAIT_ROW: begin
        if (accept_s) begin
          load_s        = 1'b1;
          row_cnt_nxt_s = row_cnt_r + RCW'(1);
          tap_nxt_s     = 2'd0;
          state_nxt_s   = MUL;
        end else begin
          state_nxt_s   = WAIT_ROW;
        end
      end
      DRAIN: begin
        // Last product of the window lands in acc on this edge
        state_nxt_s = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        tap_nxt_s     = 2'd0;
        row_cnt_nxt_s = '0;
      end
    endcase
  end

  // Accumulate the delayed product; wrap or saturate on carry-out of AW bits
  always_comb begin
    sum_s     = {1'b0, acc_r} + {{(AW + 1 - DW){1'b0}}, bus.mm_product};
    acc_nxt_s = acc_r;
    ovf_nxt_s = ovf_r;
    if (clr_s) begin
      acc_nxt_s = '0;
      ovf_nxt_s = 1'b0;
    end else if (pend_r) begin
`ifdef CONV_TAP_SAT_EN
      if (ovf_r || sum_s[AW]) begin
        acc_nxt_s = {AW{1'b1}};
        ovf_nxt_s = 1'b1;
      end else begin
        acc_nxt_s = sum_s[AW-1:0];
        ovf_nxt_s = ovf_r;
      end
`else
      acc_nxt_s = sum_s[AW-1:0];
      ovf_nxt_s = ovf_r | sum_s[AW];
`endif
    end else begin
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
    end
  end

  // State, datapath and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      tap_r       <= 2'd0;
      row_cnt_r   <= '0;
      pend_r      <= 1'b0;
      acc_r       <= '0;
      ovf_r       <= 1'b0;
      mm_a_r      <= '0;
      mm_k_r      <= '0;
      mm_sel_r    <= 2'd0;
      row_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      tap_r       <= tap_nxt_s;
      row_cnt_r   <= row_cnt_nxt_s;
      pend_r      <= (state_r == MUL);
      acc_r       <= acc_nxt_s;
      ovf_r       <= ovf_nxt_s;
      if (load_s) begin
        mm_a_r <= bus.row_a;
        mm_k_r <= bus.row_k;
      end else begin
        mm_a_r <= mm_a_r;
        mm_k_r <= mm_k_r;
      end
      mm_sel_r    <= (state_nxt_s == MUL) ? (tap_nxt_s + 2'd1) : 2'd0;
      row_ready_r <= (state_nxt_s == IDLE) || (state_nxt_s == WAIT_ROW);
      out_valid_r <= (state_nxt_s == DONE);
    end
  end

  assign bus.row_ready = row_ready_r;
  assign bus.mm_sel    = mm_sel_r;
  assign bus.mm_a      = mm_a_r;
  assign bus.mm_k      = mm_k_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_r;
  assign bus.out_ovf   = ovf_r;

endmodule

// File: tb/tb_conv_tap_sched.sv
// tb_conv_tap_sched: randomized and directed stimulus for conv_tap_sched with a
// window-level reference model. Main instance: ROWS=3, DW=8, AW=8 (so random
// windows overflow often); second instance: ROWS=1, DW=8, AW=12.
module tb_conv_tap_sched;

  localparam int ROWS = 3;
  localparam int DW   = 8;
  localparam int AW   = 8;
`ifdef CONV_TAP_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  conv_tap_sched_if #(.DW(DW), .AW(AW)) if0 ();
  conv_tap_sched_if #(.DW(8),  .AW(12)) if1 ();

  conv_tap_sched #(.ROWS(ROWS), .DW(DW), .AW(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0)
  );

  conv_tap_sched #(.ROWS(1), .DW(8), .AW(12)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] tap_prod(input logic [1:0] sel, input logic [23:0] a,
                                          input logic [23:0] k, input logic [7:0] hold);
    int idx;
    if (sel == 2'd0) return hold;
    idx = int'(sel) - 1;
    return 8'((a[idx*8 +: 8] * k[idx*8 +: 8]) & 255);
  endfunction

  // Multiplier stubs: registered product one cycle after the select
  always @(posedge clk) begin
    if (!rst_n) if0.mm_product <= 8'd0;
    else        if0.mm_product <= tap_prod(if0.mm_sel, if0.mm_a, if0.mm_k, if0.mm_product);
  end
  always @(posedge clk) begin
    if (!rst_n) if1.mm_product <= 8'd0;
    else        if1.mm_product <= tap_prod(if1.mm_sel, if1.mm_a, if1.mm_k, if1.mm_product);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model (main instance) ----------------
  int          n = 0;            // negedge count
  int          last_acc = -100;  // negedge before the most recent row accept
  int          first_acc = 0;
  int          win_rows = 0;
  bit          all_in = 1'b0;
  bit          rst_at_edge = 1'b1;
  bit          seen_v = 1'b0;
  int          prods[$];
  logic [23:0] exp_a = 24'd0;
  logic [23:0] exp_k = 24'd0;
  int          exp_sum = 0;
  bit          exp_ovf = 1'b0;
  int          dut_lat = 0;
  int          dut_sum = 0;
  bit          dut_ovf = 1'b0;
  int          m_d;
  bit          m_ev;
  bit          m_er;
  logic [1:0]  m_es;

  function automatic void window_sum(output int s, output bit o);
    int acc;
    acc = 0;
    o   = 1'b0;
    foreach (prods[i]) begin
      if (SAT && o) begin
        acc = 255;
      end else if (acc + prods[i] > 255) begin
        o   = 1'b1;
        acc = SAT ? 255 : (acc + prods[i]) % 256;
      end else begin
        acc = acc + prods[i];
      end
    end
    s = acc;
  endfunction

  // Compare process: checks every output on every negedge against the model
  initial begin
    forever begin
      @(negedge clk);
      n = n + 1;
      if (rst_at_edge) begin
        chk("rst_row_ready", 32'(if0.row_ready), 32'd0);
        chk("rst_mm_sel",    32'(if0.mm_sel),    32'd0);
        chk("rst_mm_a",      32'(if0.mm_a),      32'd0);
        chk("rst_mm_k",      32'(if0.mm_k),      32'd0);
        chk("rst_out_valid", 32'(if0.out_valid), 32'd0);
        chk("rst_out_sum",   32'(if0.out_sum),   32'd0);
        chk("rst_out_ovf",   32'(if0.out_ovf),   32'd0);
        win_rows = 0;
        all_in   = 1'b0;
        last_acc = n - 100;
        exp_a    = 24'd0;
        exp_k    = 24'd0;
      end else begin
        m_d  = n - last_acc;
        m_es = (m_d >= 1 && m_d <= 3) ? 2'(m_d) : 2'd0;
        m_ev = all_in && (m_d >= 5);
        m_er = all_in ? 1'b0 : ((win_rows > 0) ? (m_d >= 4) : 1'b1);
        chk("mm_sel",    32'(if0.mm_sel),    32'(m_es));
        chk("mm_a",      32'(if0.mm_a),      32'(exp_a));
        chk("mm_k",      32'(if0.mm_k),      32'(exp_k));
        chk("out_valid", 32'(if0.out_valid), 32'(m_ev));
        chk("row_ready", 32'(if0.row_ready), 32'(m_er));
        if (m_ev) begin
          chk("out_sum", 32'(if0.out_sum), 32'(exp_sum));
          chk("out_ovf", 32'(if0.out_ovf), 32'(exp_ovf));
        end
        if (if0.out_valid && !seen_v) begin
          seen_v  = 1'b1;
          dut_lat = n - first_acc;
        end
        if (rst_n) begin
          if (m_ev && if0.out_ready) begin
            dut_sum  = int'(if0.out_sum);
            dut_ovf  = if0.out_ovf;
            win_rows = 0;
            all_in   = 1'b0;
          end else if (m_er && if0.row_valid) begin
            if (win_rows == 0) begin
              prods.delete();
              first_acc = n;
              seen_v    = 1'b0;
            end
            for (int t = 0; t < 3; t++)
              prods.push_back((int'(if0.row_a[t*8 +: 8]) * int'(if0.row_k[t*8 +: 8])) % 256);
            exp_a    = if0.row_a;
            exp_k    = if0.row_k;
            last_acc = n;
            win_rows = win_rows + 1;
            if (win_rows == ROWS) begin
              all_in = 1'b1;
              window_sum(exp_sum, exp_ovf);
            end
          end
        end
      end
      rst_at_edge = !rst_n;
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_row(input logic [23:0] a, input logic [23:0] k, input int gap);
    int t;
    if0.row_valid = 1'b1;
    if0.row_a     = a;
    if0.row_k     = k;
    t = 0;
    while (!if0.row_ready && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) chk("row_accept_timeout", 32'd0, 32'd1);
    step();
    if0.row_valid = 1'b0;
    if0.row_a     = 24'($urandom);
    if0.row_k     = 24'($urandom);
    repeat (gap) step();
  endtask

  task automatic finish_window(input int bp);
    int t;
    t = 0;
    while (!if0.out_valid && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) chk("out_valid_timeout", 32'd0, 32'd1);
    repeat (bp) step();
    if0.out_ready = 1'b1;
    step();
    if0.out_ready = 1'b0;
  endtask

  task automatic run_window(input logic [23:0] a, input logic [23:0] k, input int gap, input int bp);
    for (int r = 0; r < ROWS; r++) send_row(a, k, gap);
    finish_window(bp);
  endtask

  localparam logic [23:0] A1 = {8'd3, 8'd2, 8'd1};
  localparam logic [23:0] K1 = {8'd6, 8'd5, 8'd4};

  initial begin
    int cnt;
    rst_n         = 1'b0;
    if0.row_valid = 1'b0;
    if0.row_a     = 24'd0;
    if0.row_k     = 24'd0;
    if0.out_ready = 1'b0;
    if1.row_valid = 1'b0;
    if1.row_a     = 24'd0;
    if1.row_k     = 24'd0;
    if1.out_ready = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // ROWS=1 instance: a=(255,1,0), k=(1,1,0) -> 256 at c5
    if1.row_valid = 1'b1;
    if1.row_a     = {8'd0, 8'd1, 8'd255};
    if1.row_k     = {8'd0, 8'd1, 8'd1};
    cnt = 0;
    while (!if1.row_ready && cnt < 20) begin
      step();
      cnt++;
    end
    step();
    if1.row_valid = 1'b0;
    cnt = 0;
    while (!if1.out_valid && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    chk("rows1_latency", 32'(cnt), 32'd5);
    chk("rows1_sum",     32'(if1.out_sum), 32'd256);
    chk("rows1_ovf",     32'(if1.out_ovf), 32'd0);
    step();
    if1.out_ready = 1'b1;
    step();
    if1.out_ready = 1'b0;

    // Back-to-back rows
    run_window(A1, K1, 0, 0);
    chk("b2b_latency", 32'(dut_lat), 32'd13);
    chk("b2b_sum",     32'(dut_sum), 32'd96);
    chk("b2b_ovf",     32'(dut_ovf), 32'd0);

    // Three-cycle stall in every WAIT_ROW
    run_window(A1, K1, 6, 0);
    chk("gap_latency", 32'(dut_lat), 32'd19);
    chk("gap_sum",     32'(dut_sum), 32'd96);

    // Overflow: nine products of 200 into an 8-bit accumulator
    run_window({8'd20, 8'd20, 8'd20}, {8'd10, 8'd10, 8'd10}, 0, 0);
    chk("ovf_sum", 32'(dut_sum), SAT ? 32'd255 : 32'd8);
    chk("ovf_flag", 32'(dut_ovf), 32'd1);

    // Backpressure: five cycles of out_ready low in DONE
    run_window(A1, K1, 0, 5);
    chk("bp_sum", 32'(dut_sum), 32'd96);

    // Reset in the middle of a window (rst_n low at c6)
    if0.row_valid = 1'b1;
    if0.row_a     = A1;
    if0.row_k     = K1;
    cnt = 0;
    while (!if0.row_ready && cnt < 20) begin
      step();
      cnt++;
    end
    step();
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n         = 1'b1;
    if0.row_valid = 1'b0;
    repeat (20) step();
    run_window(A1, K1, 0, 0);
    chk("post_rst_sum", 32'(dut_sum), 32'd96);

    // Randomized windows: data, row gaps and backpressure
    for (int w = 0; w < 30; w++) begin
      for (int r = 0; r < ROWS; r++)
        send_row(24'($urandom), 24'($urandom), int'($urandom_range(0, 5)));
      finish_window(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
